// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback path.
package rf_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last is granted.
//   last_grant_q | meaning
//   REQ_ALU      | side A won the most recent grant, B wins the next tie
//   REQ_MEM      | side B won the most recent grant (reset), A wins the next tie
module rr_arb2
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  req_e last_grant_q;

  assign gnt_a_o = req_a_i & (~req_b_i | (last_grant_q == REQ_MEM));
  assign gnt_b_o = req_b_i & (~req_a_i | (last_grant_q == REQ_ALU));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= REQ_MEM;
    end else if (gnt_a_o) begin
      last_grant_q <= REQ_ALU;
    end else if (gnt_b_o) begin
      last_grant_q <= REQ_MEM;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the ALU and load writeback paths and
// keeps the per-register busy scoreboard that decode uses for RAW and WAW stalls.
module rf_wb_arbiter
  import rf_pkg::wb_req_t;
#(
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int DATA_W   = rf_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_rd,
  output logic              alloc_ready,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_w_en,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data
);

  wb_req_t             alu_req;
  wb_req_t             mem_req;
  wb_req_t             wb_req;
  logic                wb_fire;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                rf_w_en_q;
  logic [ADDR_W-1:0]   rf_w_addr_q;
  logic [DATA_W-1:0]   rf_w_data_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a_i (alu_valid),
    .req_b_i (mem_valid),
    .gnt_a_o (alu_ready),
    .gnt_b_o (mem_ready)
  );

  assign alu_req = '{rd: alu_rd, data: alu_data};
  assign mem_req = '{rd: mem_rd, data: mem_data};
  assign wb_fire = alu_ready | mem_ready;
  assign wb_req  = alu_ready ? alu_req : mem_req;

  // Reads see pre-edge state only, so a same-cycle clear still stalls the alloc.
  assign alloc_ready = alloc_valid & ~busy_q[alloc_rd];
  assign rs1_busy    = busy_q[chk_rs1];
  assign rs2_busy    = busy_q[chk_rs2];

  always_comb begin
    busy_d = busy_q;
    if (wb_fire) begin
      busy_d[wb_req.rd] = 1'b0;
    end
    if (alloc_ready && (alloc_rd != '0)) begin
      busy_d[alloc_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      rf_w_en_q   <= 1'b0;
      rf_w_addr_q <= '0;
      rf_w_data_q <= '0;
    end else begin
      busy_q    <= busy_d;
      rf_w_en_q <= wb_fire && (wb_req.rd != '0);
      if (wb_fire) begin
        rf_w_addr_q <= wb_req.rd;
        rf_w_data_q <= wb_req.data;
      end
    end
  end

  assign rf_w_en   = rf_w_en_q;
  assign rf_w_addr = rf_w_addr_q;
  assign rf_w_data = rf_w_data_q;

  // A writeback to a register nobody allocated is a requester protocol error.
  wb_to_busy_rd : assert property (@(posedge clk) disable iff (!rst_n)
    (wb_fire && (wb_req.rd != '0)) |-> busy_q[wb_req.rd]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level model of the scoreboard and round-robin rules.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        rf_w_en;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;

  int tests_run = 0;
  int fails = 0;

  // Reference model state: busy flags, who won the last grant, expected write port.
  bit          mbusy[32];
  bit          m_last_mem;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  rf_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .rf_w_en     (rf_w_en),
    .rf_w_addr   (rf_w_addr),
    .rf_w_data   (rf_w_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  function automatic bit exp_alu_gnt();
    if (!alu_valid) return 1'b0;
    if (!mem_valid) return 1'b1;
    return m_last_mem;
  endfunction

  function automatic bit exp_mem_gnt();
    if (!mem_valid) return 1'b0;
    if (!alu_valid) return 1'b1;
    return !m_last_mem;
  endfunction

  function automatic bit exp_alloc();
    return alloc_valid && !mbusy[alloc_rd];
  endfunction

  // Picks a register the model holds busy, skipping one excluded address.
  function automatic bit pick_busy(input bit excl_en, input logic [4:0] excl,
                                   output logic [4:0] rd);
    int start;
    int r;
    start = $urandom_range(31, 1);
    for (int k = 0; k < 31; k++) begin
      r = 1 + (start - 1 + k) % 31;
      if (mbusy[r] && !(excl_en && excl == 5'(r))) begin
        rd = 5'(r);
        return 1'b1;
      end
    end
    rd = '0;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    m_last_mem = 1'b1;
    m_wen = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advances the model across the coming posedge using the inputs now driven.
  task automatic model_edge();
    bit ga;
    bit gm;
    bit gal;
    logic [4:0]  rd;
    logic [31:0] d;
    ga = exp_alu_gnt();
    gm = exp_mem_gnt();
    gal = exp_alloc();
    rd = '0;
    d = '0;
    if (ga) begin
      rd = alu_rd; d = alu_data; m_last_mem = 1'b0;
    end else if (gm) begin
      rd = mem_rd; d = mem_data; m_last_mem = 1'b1;
    end
    m_wen = (ga || gm) && (rd != 5'd0);
    if (ga || gm) begin
      m_waddr = rd;
      m_wdata = d;
      mbusy[rd] = 1'b0;
    end
    if (gal && alloc_rd != 5'd0) mbusy[alloc_rd] = 1'b1;
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (rf_w_en !== 1'b0) begin fails++; $display("FAIL reset_wen got %0b want 0", rf_w_en); end
    tests_run++;
    if (rf_w_addr !== 5'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", rf_w_addr); end
    tests_run++;
    if (rf_w_data !== 32'd0) begin fails++; $display("FAIL reset_data got %h want 0", rf_w_data); end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk_rs1 = 5'(i);
      chk_rs2 = 5'(31 - i);
      #1;
      tests_run++;
      if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_busy[%0d] got %0b%0b want 00", i, rs1_busy, rs2_busy);
      end
      tests_run++;
      if (rf_w_en !== 1'b0) begin fails++; $display("FAIL idle_wen got %0b want 0", rf_w_en); end
    end
    @(negedge clk);
  endtask

  task automatic test_alu_basic();
    alloc_valid = 1'b1; alloc_rd = 5'd5; #1;
    tests_run++;
    if (alloc_ready !== 1'b1) begin fails++; $display("FAIL basic_alloc got %0b want 1", alloc_ready); end
    step();
    alloc_valid = 1'b0;
    chk_rs1 = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; #1;
    tests_run++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      fails++; $display("FAIL basic_grant got alu=%0b mem=%0b want 1 0", alu_ready, mem_ready);
    end
    tests_run++;
    if (rs1_busy !== 1'b1) begin fails++; $display("FAIL basic_busy_pre got %0b want 1", rs1_busy); end
    step();
    alu_valid = 1'b0;
    tests_run++;
    if (rf_w_en !== 1'b1 || rf_w_addr !== 5'd5 || rf_w_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL basic_write got en=%0b addr=%0d data=%h want 1 5 deadbeef",
               rf_w_en, rf_w_addr, rf_w_data);
    end
    #1;
    tests_run++;
    if (rs1_busy !== 1'b0) begin fails++; $display("FAIL basic_busy_post got %0b want 0", rs1_busy); end
    step();
    tests_run++;
    if (rf_w_en !== 1'b0 || rf_w_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL basic_hold got en=%0b data=%h want 0 deadbeef", rf_w_en, rf_w_data);
    end
  endtask

  task automatic test_alternate();
    bit want_alu;
    logic [31:0] a_d;
    logic [31:0] m_d;
    do_reset();
    alloc_valid = 1'b1; alloc_rd = 5'd3; step();
    alloc_rd = 5'd4; step();
    alloc_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = $urandom;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = $urandom;
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b0;
      if (!mbusy[3]) begin alloc_valid = 1'b1; alloc_rd = 5'd3; end
      else if (!mbusy[4]) begin alloc_valid = 1'b1; alloc_rd = 5'd4; end
      #1;
      want_alu = (i % 2 == 0);
      a_d = alu_data;
      m_d = mem_data;
      tests_run++;
      if (alu_ready !== want_alu || mem_ready !== !want_alu) begin
        fails++;
        $display("FAIL alt_grant[%0d] got alu=%0b mem=%0b want alu=%0b", i, alu_ready, mem_ready, want_alu);
      end
      step();
      tests_run++;
      if (rf_w_en !== 1'b1 || rf_w_addr !== (want_alu ? 5'd3 : 5'd4) ||
          rf_w_data !== (want_alu ? a_d : m_d)) begin
        fails++;
        $display("FAIL alt_write[%0d] got en=%0b addr=%0d data=%h want 1 %0d %h", i, rf_w_en,
                 rf_w_addr, rf_w_data, want_alu ? 3 : 4, want_alu ? a_d : m_d);
      end
      if (want_alu) alu_data = $urandom;
      else mem_data = $urandom;
    end
    idle_inputs();
  endtask

  task automatic test_waw();
    do_reset();
    alloc_valid = 1'b1; alloc_rd = 5'd7; #1;
    tests_run++;
    if (alloc_ready !== 1'b1) begin fails++; $display("FAIL waw_first got %0b want 1", alloc_ready); end
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (alloc_ready !== 1'b0) begin fails++; $display("FAIL waw_stall[%0d] got %0b want 0", i, alloc_ready); end
      step();
    end
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0777; #1;
    tests_run++;
    if (alloc_ready !== 1'b0 || alu_ready !== 1'b1) begin
      fails++; $display("FAIL waw_same_cycle got alloc=%0b alu=%0b want 0 1", alloc_ready, alu_ready);
    end
    step();
    alu_valid = 1'b0; #1;
    tests_run++;
    if (alloc_ready !== 1'b1) begin fails++; $display("FAIL waw_release got %0b want 1", alloc_ready); end
    step();
    alloc_valid = 1'b0;
    alu_valid = 1'b1; alu_data = 32'h0000_0778;
    step();
    alu_valid = 1'b0;
    tests_run++;
    if (rf_w_en !== 1'b1 || rf_w_addr !== 5'd7 || rf_w_data !== 32'h0000_0778) begin
      fails++; $display("FAIL waw_drain got en=%0b addr=%0d data=%h want 1 7 778", rf_w_en, rf_w_addr, rf_w_data);
    end
  endtask

  task automatic test_rd0();
    chk_rs1 = 5'd0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_1234; #1;
    tests_run++;
    if (mem_ready !== 1'b1) begin fails++; $display("FAIL rd0_ready got %0b want 1", mem_ready); end
    step();
    mem_valid = 1'b0;
    tests_run++;
    if (rf_w_en !== 1'b0) begin fails++; $display("FAIL rd0_wen got %0b want 0", rf_w_en); end
    alloc_valid = 1'b1; alloc_rd = 5'd0;
    step();
    alloc_valid = 1'b0; #1;
    tests_run++;
    if (rs1_busy !== 1'b0) begin fails++; $display("FAIL rd0_busy got %0b want 0", rs1_busy); end
  endtask

  task automatic test_chk();
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    step();
    alloc_valid = 1'b0;
    chk_rs1 = 5'd9; chk_rs2 = 5'd10; #1;
    tests_run++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
      fails++; $display("FAIL chk_alloc got rs1=%0b rs2=%0b want 1 0", rs1_busy, rs2_busy);
    end
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = $urandom; #1;
    tests_run++;
    if (mem_ready !== 1'b1 || rs1_busy !== 1'b1) begin
      fails++; $display("FAIL chk_grant_cycle got ready=%0b rs1=%0b want 1 1", mem_ready, rs1_busy);
    end
    step();
    mem_valid = 1'b0; #1;
    tests_run++;
    if (rs1_busy !== 1'b0 || rf_w_addr !== 5'd9) begin
      fails++; $display("FAIL chk_cleared got rs1=%0b addr=%0d want 0 9", rs1_busy, rf_w_addr);
    end
  endtask

  task automatic test_random();
    bit e_alu;
    bit e_mem;
    bit e_alloc;
    for (int c = 0; c < 1500; c++) begin
      if (!alu_valid && $urandom_range(1, 0) == 1) begin
        if ($urandom_range(7, 0) == 0) begin alu_rd = 5'd0; alu_valid = 1'b1; end
        else alu_valid = pick_busy(mem_valid, mem_rd, alu_rd);
        alu_data = $urandom;
      end
      if (!mem_valid && $urandom_range(1, 0) == 1) begin
        if ($urandom_range(7, 0) == 0) begin mem_rd = 5'd0; mem_valid = 1'b1; end
        else mem_valid = pick_busy(alu_valid, alu_rd, mem_rd);
        mem_data = $urandom;
      end
      alloc_valid = ($urandom_range(1, 0) == 1);
      alloc_rd = 5'($urandom_range(31, 0));
      chk_rs1 = 5'($urandom_range(31, 0));
      chk_rs2 = 5'($urandom_range(31, 0));
      #1;
      e_alu = exp_alu_gnt();
      e_mem = exp_mem_gnt();
      e_alloc = exp_alloc();
      tests_run++;
      if (alu_ready !== e_alu || mem_ready !== e_mem) begin
        fails++; $display("FAIL rnd_grant[%0d] got %0b%0b want %0b%0b", c, alu_ready, mem_ready, e_alu, e_mem);
      end
      tests_run++;
      if (alloc_ready !== e_alloc) begin
        fails++; $display("FAIL rnd_alloc[%0d] rd=%0d got %0b want %0b", c, alloc_rd, alloc_ready, e_alloc);
      end
      tests_run++;
      if (rs1_busy !== mbusy[chk_rs1] || rs2_busy !== mbusy[chk_rs2]) begin
        fails++;
        $display("FAIL rnd_busy[%0d] got %0b%0b want %0b%0b", c, rs1_busy, rs2_busy,
                 mbusy[chk_rs1], mbusy[chk_rs2]);
      end
      step();
      tests_run++;
      if (rf_w_en !== m_wen || rf_w_addr !== m_waddr || rf_w_data !== m_wdata) begin
        fails++;
        $display("FAIL rnd_write[%0d] got %0b %0d %h want %0b %0d %h", c, rf_w_en, rf_w_addr,
                 rf_w_data, m_wen, m_waddr, m_wdata);
      end
      if (e_alu) alu_valid = 1'b0;
      if (e_mem) mem_valid = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    alloc_valid = 1'b1;
    for (int r = 20; r < 26; r++) begin
      alloc_rd = 5'(r);
      if (!(alu_valid && alu_rd == 5'(r)) && !(mem_valid && mem_rd == 5'(r))) step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (rf_w_en !== 1'b0 || rf_w_addr !== 5'd0 || rf_w_data !== 32'd0) begin
      fails++; $display("FAIL async_rf got %0b %0d %h want 0 0 0", rf_w_en, rf_w_addr, rf_w_data);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk_rs1 = 5'(i);
      chk_rs2 = 5'(31 - i);
      #1;
      tests_run++;
      if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
        fails++; $display("FAIL async_busy[%0d] got %0b%0b want 00", i, rs1_busy, rs2_busy);
      end
    end
    idle_inputs();
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (rf_w_en !== 1'b0) begin fails++; $display("FAIL async_after got %0b want 0", rf_w_en); end
  endtask

  initial begin
    idle_inputs();
    reset_model();
    test_reset();
    test_alu_basic();
    test_alternate();
    test_waw();
    test_rd0();
    test_chk();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sequences the register-file write port and shares it between two writeback requesters: the ALU result path and the load/memory path.
- Arbitrates them round-robin and issues one registered write per cycle to the 32x32 register heap's single write port.
- Keeps a per-register busy scoreboard, set at instruction issue and cleared at writeback, so decode can stall on pending results and on write-after-write hazards.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W == NUM_REGS.
- DATA_W, 32, write data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- alloc_valid  in  1  issue stage marks a destination register pending.
- alloc_rd  in  ADDR_W  destination register being allocated.
- alloc_ready  out  1  allocation accepted this cycle (combinational).
- chk_rs1  in  ADDR_W  source register 1 to check.
- chk_rs2  in  ADDR_W  source register 2 to check.
- rs1_busy  out  1  chk_rs1 has a pending write (combinational).
- rs2_busy  out  1  chk_rs2 has a pending write (combinational).
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request granted this cycle (combinational).
- mem_valid  in  1  load writeback request.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request granted this cycle (combinational).
- rf_w_en  out  1  register-file write enable (registered).
- rf_w_addr  out  ADDR_W  register-file write address (registered).
- rf_w_data  out  DATA_W  register-file write data (registered).

Behaviour:
- Reset (async, any time): busy[] all 0; rf_w_en=0, rf_w_addr=0, rf_w_data=0; last_grant=MEM, so ALU wins the first tie.
- Handshake: a transfer occurs when valid&ready. Once valid is asserted, the requester holds valid, rd and data stable until ready. ready never depends on the same requester's data.
- Arbitration, combinational each cycle:
  - Only one requester valid: it is granted.
  - Both valid: grant the one not in last_grant.
  - last_grant updates on posedge only when a grant occurs.
- Write issue:
  - On the posedge of a transfer, rf_w_en <= (rd != 0), rf_w_addr <= rd, rf_w_data <= data.
  - With no transfer, rf_w_en <= 0; addr and data hold their values.
  - The register heap samples on the following negedge, so a granted result is architecturally written about 1.5 cycles after valid is first seen, assuming a grant in that cycle.
- Throughput: one write per cycle. A continuously valid single requester sees ready=1 every cycle. With both continuously valid, the two requesters alternate strictly.
- Scoreboard:
  - busy[0] is constantly 0.
  - alloc_ready = alloc_valid ? ~busy[alloc_rd] : 0. This stalls WAW.
  - A clear of the same register in the same cycle does not make alloc_ready=1; stall one more cycle.
  - On alloc fire with alloc_rd != 0, busy[alloc_rd] <= 1 at posedge.
  - On a writeback transfer, busy[rd] <= 0 at posedge.
  - Set and clear of different registers in the same cycle both take effect.
  - Set and clear of the same register in the same cycle cannot occur, because alloc is stalled.
- rs1_busy = busy[chk_rs1], rs2_busy = busy[chk_rs2]. There is no forwarding: busy reads the pre-edge state, and a register cleared at edge N reads 0 from edge N onward.
- rd=0 writeback: handshake completes, no rf write, no scoreboard change.
- Writeback to a non-busy rd: the write is performed and the scoreboard is unchanged. This is a protocol error, flagged by assertion only.

Decomposition:
- Shared package rf_pkg:
  - ADDR_W, DATA_W, NUM_REGS constants.
  - Requester enum REQ_ALU=0, REQ_MEM=1.
  - A struct for a writeback request {rd, data}.
- One natural sub-module: rr_arb2, a two-way round-robin arbiter with a registered last_grant, reusable elsewhere.
- The scoreboard stays inline.

Test Plan:
- Reset, then idle: rf_w_en=0, rs1_busy=rs2_busy=0 for all 32 addresses; assert rst_n low mid-burst and all busy bits clear asynchronously.
- Alloc rd=5, then alu_valid with rd=5, data=0xDEADBEEF -> alu_ready=1 the same cycle; next posedge rf_w_en=1, addr=5, data=0xDEADBEEF; busy[5]=0 afterwards.
- Both valid every cycle (ALU rd=3, MEM rd=4) -> grants ALU, MEM, ALU, MEM, starting with ALU after reset; rf_w_addr sequence 3,4,3,4.
- Alloc rd=7 twice back-to-back -> second alloc_ready=0 until an ALU writeback to 7 completes; also the same-cycle clear case stalls one extra cycle.
- mem_valid with rd=0, data=0x1234 -> mem_ready=1, rf_w_en stays 0, busy[0]=0.
- chk_rs1=9, chk_rs2=10 with only rd=9 allocated -> rs1_busy=1, rs2_busy=0; after MEM writeback to 9, rs1_busy=0 the cycle after the grant.
